cnu_wr_update_ctrl_mc: RTL

- Multi-channel, parametrised successor of the single-channel CNU write/update handshake.
- One Moore FSM per CNU group sequences the phases init-load -> write -> wait-for-read-finish -> pipe-load, across decoding iterations.
- Iteration strobes are synchronised into the read_clk domain and counted up to a runtime iteration limit.
- Sits between the decoding-process-control FSM and the decomposed CNU LUT/memory banks.

---
 rtl/cnu_wr_update_ctrl_mc_if.sv | 21 ++
 rtl/cnu_wr_update_ctrl_mc.sv | 93 +++++++++
 2 files changed

// File: rtl/cnu_wr_update_ctrl_mc_if.sv
// cnu_wr_update_ctrl_mc_if: handshake bundle between decode control, the CNU update controller and the CNU banks.
interface cnu_wr_update_ctrl_mc_if #(parameter int CH_NUM = 4, parameter int ITER_W = 5);
    logic              iter_update_i;
    logic [CH_NUM-1:0] cnu_init_load_en_i;
    logic [CH_NUM-1:0] cnu_rd_finish_i;
    logic [ITER_W-1:0] max_iter_i;
    logic [CH_NUM-1:0] cnu_wr_o;
    logic [CH_NUM-1:0] init_load_o;
    logic [CH_NUM-1:0] pipe_load_o;
    logic [ITER_W-1:0] iter_cnt_o;
    logic              all_done_o;
    logic              proto_err_o;
    modport master (
        input  iter_update_i, cnu_init_load_en_i, cnu_rd_finish_i, max_iter_i,
        output cnu_wr_o, init_load_o, pipe_load_o, iter_cnt_o, all_done_o, proto_err_o
    );
    modport slave (
        output iter_update_i, cnu_init_load_en_i, cnu_rd_finish_i, max_iter_i,
        input  cnu_wr_o, init_load_o, pipe_load_o, iter_cnt_o, all_done_o, proto_err_o
    );
endinterface

// File: rtl/cnu_wr_update_ctrl_mc.sv
// cnu_wr_update_ctrl_mc: per-channel CNU init/write/hold/pipe sequencing with synchronised iteration counting.
// Defining CNU_ITER_SYNC_BYPASS_EN replaces the iter_update_i synchroniser with a single edge-detect flop.
module cnu_wr_update_ctrl_mc #(
    parameter int CH_NUM    = 4,
    parameter int CDC_DEPTH = 2,
    parameter int PIPE_LEN  = 2,
    parameter int ITER_W    = 5
) (
    input logic read_clk,
    input logic rstn,
    cnu_wr_update_ctrl_mc_if.master bus
);
    localparam int PW = PIPE_LEN > 1 ? $clog2(PIPE_LEN) : 1;
    typedef enum logic [2:0] {IDLE, INIT, WRITE, HOLD, PIPE} state_t;
    state_t            st [CH_NUM];
    state_t            nx [CH_NUM];
    logic [PW-1:0]     pcnt [CH_NUM];
    logic [ITER_W-1:0] limit;
    logic              iter_pulse, any_busy, any_start, pipe_exit, all_idle_nx, lim_hit;
    logic [CH_NUM-1:0] err;
`ifdef CNU_ITER_SYNC_BYPASS_EN
    logic iter_d;
    always_ff @(posedge read_clk or negedge rstn)
        if (!rstn) iter_d <= 1'b0;
        else iter_d <= bus.iter_update_i;
    assign iter_pulse = bus.iter_update_i & ~iter_d;
`else
    logic [CDC_DEPTH-1:0] sync;
    logic                 sync_d;
    always_ff @(posedge read_clk or negedge rstn)
        if (!rstn) begin
            sync   <= '0;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[CDC_DEPTH-2:0], bus.iter_update_i};
            sync_d <= sync[CDC_DEPTH-1];
        end
    assign iter_pulse = sync[CDC_DEPTH-1] & ~sync_d;
`endif
    assign lim_hit = bus.iter_cnt_o >= limit;
    always_comb begin
        any_busy    = 1'b0;
        any_start   = 1'b0;
        pipe_exit   = 1'b0;
        all_idle_nx = 1'b1;
        err         = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            nx[c] = st[c];
            case (st[c])
                IDLE:    nx[c] = bus.cnu_init_load_en_i[c] ? INIT : IDLE;
                INIT:    nx[c] = bus.cnu_init_load_en_i[c] ? INIT : WRITE;
                WRITE:   nx[c] = iter_pulse ? HOLD : WRITE;
                HOLD:    nx[c] = bus.cnu_rd_finish_i[c] ? PIPE : HOLD;
                PIPE:    nx[c] = pcnt[c] != '0 ? PIPE : (lim_hit ? IDLE : WRITE);
                default: nx[c] = IDLE;
            endcase
            any_busy    |= st[c] != IDLE;
            any_start   |= st[c] == IDLE && nx[c] == INIT;
            pipe_exit   |= st[c] == PIPE && nx[c] == IDLE;
            all_idle_nx &= nx[c] == IDLE;
            err[c] = (bus.cnu_init_load_en_i[c] && st[c] inside {WRITE, HOLD, PIPE}) ||
                     (bus.cnu_rd_finish_i[c] && st[c] == INIT);
        end
    end
    always_ff @(posedge read_clk or negedge rstn)
        if (!rstn) begin
            for (int c = 0; c < CH_NUM; c++) begin
                st[c]   <= IDLE;
                pcnt[c] <= '0;
            end
            bus.cnu_wr_o    <= '0;
            bus.init_load_o <= '0;
            bus.pipe_load_o <= '0;
            bus.iter_cnt_o  <= '0;
            bus.all_done_o  <= 1'b0;
            bus.proto_err_o <= 1'b0;
            limit           <= '0;
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                st[c]              <= nx[c];
                pcnt[c]            <= st[c] == PIPE ? pcnt[c] - 1'b1 : PW'(PIPE_LEN - 1);
                bus.cnu_wr_o[c]    <= nx[c] == WRITE;
                bus.init_load_o[c] <= nx[c] == INIT;
                bus.pipe_load_o[c] <= nx[c] == PIPE;
            end
            // a zero limit still runs one iteration
            if (!any_busy && any_start) limit <= bus.max_iter_i == '0 ? ITER_W'(1) : bus.max_iter_i;
            bus.iter_cnt_o  <= bus.all_done_o ? '0 :
                               bus.iter_cnt_o + ITER_W'(iter_pulse && any_busy && !(&bus.iter_cnt_o));
            bus.all_done_o  <= pipe_exit && all_idle_nx;
            bus.proto_err_o <= bus.proto_err_o | (|err);
        end
endmodule
